// File: rtl/tanhx_pkg.sv
// Shared constants and tag type for the shared tanhx activation front end.
package tanhx_pkg;
    localparam int unsigned DWIDTH         = 32;
    localparam int unsigned EXPONENT_WIDTH = 8;
    localparam int unsigned BIAS           = 127;
    localparam logic [DWIDTH-1:0] POS_ONE  = 32'h3F80_0000;
    localparam logic [DWIDTH-1:0] NEG_ONE  = 32'hBF80_0000;

    // Tag id is sized for up to 256 requesters; the top narrows it to IDW.
    localparam int unsigned TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/tanhx_share_arbiter_rr_arbiter.sv
// Round-robin grant search starting at rr_ptr; purely combinational.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             any_grant
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (req[IDW'(idx)]) begin
                grant_idx = IDW'(idx);
                any_grant = 1'b1;
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/tanhx_share_arbiter.sv
// Shares one fixed-latency tanhx unit among N_REQ requesters with a
// credit-protected result FIFO that tags each result with its requester.
module tanhx_share_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned LAT         = 2,
    parameter int unsigned OFIFO_DEPTH = 4,
    parameter int unsigned IDW         = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DWIDTH-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DWIDTH-1:0]       unit_x,
    output logic                    unit_en,
    input  logic [DWIDTH-1:0]       unit_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DWIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);
    import tanhx_pkg::*;

    localparam int unsigned CW = $clog2(OFIFO_DEPTH + 1);
    localparam int unsigned AW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;

    logic [IDW-1:0]    rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic [IDW-1:0]    grant_idx;
    logic              any_grant;
    tag_t              tag_pipe [LAT];
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     inflight;
    logic [CW:0]       occupancy;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DWIDTH-1:0] fifo_data [OFIFO_DEPTH];
    logic [IDW-1:0]    fifo_id   [OFIFO_DEPTH];
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Credits come only from registered state, so a pop frees a slot next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight = inflight + CW'(tag_pipe[i].valid);
        end
        occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight);
        credit_ok = occupancy < (CW+1)'(OFIFO_DEPTH);
        issue     = any_grant && credit_ok && unit_en;
        req_ready = issue ? grant : '0;
        unit_x    = issue ? req_data[int'(grant_idx)*int'(DWIDTH) +: DWIDTH] : '0;
        push      = tag_pipe[LAT-1].valid;
        rsp_valid = fifo_count != '0;
        pop       = rsp_valid && rsp_ready;
        rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
        rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
        busy      = (inflight != '0) || (fifo_count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unit_en    <= 1'b0;
            rr_ptr     <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            unit_en <= 1'b1;
            if (issue) begin
                rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            tag_pipe[0].valid <= issue;
            tag_pipe[0].id    <= TAG_ID_W'(grant_idx);
            for (int i = 1; i < int'(LAT); i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Result storage needs no reset; only count marks entries as live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= unit_y;
            fifo_id[wr_ptr]   <= IDW'(tag_pipe[LAT-1].id);
        end
    end
endmodule

// File: tb/tb_tanhx_share_arbiter.sv
// Directed bench for tanhx_share_arbiter with a pass-through LAT-cycle unit model.
module tb_tanhx_share_arbiter;
    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*DW-1:0]  req_data;
    logic [N_REQ-1:0]     req_ready;
    logic [DW-1:0]        unit_x;
    logic                 unit_en;
    logic [DW-1:0]        unit_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DW-1:0]        rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    tanhx_share_arbiter #(
        .N_REQ       (N_REQ),
        .DWIDTH      (DW),
        .LAT         (LAT),
        .OFIFO_DEPTH (DEPTH),
        .IDW         (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .unit_x    (unit_x),
        .unit_en   (unit_en),
        .unit_y    (unit_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the tanhx unit: operand reappears on unit_y LAT cycles later.
    logic [DW-1:0] y_pipe [LAT];
    always @(posedge clk) begin
        y_pipe[0] <= unit_x;
        for (int i = 1; i < int'(LAT); i++) begin
            y_pipe[i] <= y_pipe[i-1];
        end
    end
    assign unit_y = y_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            n_assert++;
            assert (dut.fifo_count <= 3'd4) else begin
                n_fail++;
                $error("FAIL fifo_overflow: observed %0d expected <= 4", dut.fifo_count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_data  = {4{32'h1234_5678}};
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_unit_en",   32'(unit_en), 0);
        chk("rst_unit_x",    unit_x, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_rr_ptr",    32'(dut.rr_ptr), 0);
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        #1;
        chk("en_still_low", 32'(unit_en), 0);
        tick();
        chk("en_high", 32'(unit_en), 1);
        mon_en = 1'b1;

        // Single operand from requester 0.
        req_valid      = 4'b0001;
        req_data[31:0] = 32'h3F80_0000;
        #1;
        chk("t1_ready", 32'(req_ready), 1);
        chk("t1_unit_x", unit_x, 32'h3F80_0000);
        tick();
        req_valid = '0;
        #1;
        chk("t1_busy_inflight", 32'(busy), 1);
        chk("t1_no_rsp_1", 32'(rsp_valid), 0);
        tick();
        chk("t1_no_rsp_2", 32'(rsp_valid), 0);
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_id",    32'(rsp_id), 0);
        chk("t1_rsp_data",  rsp_data, 32'h3F80_0000);
        chk("t1_busy_held", 32'(busy), 1);
        tick();
        chk("t1_rsp_gone", 32'(rsp_valid), 0);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_rr_ptr",   32'(dut.rr_ptr), 1);

        // Move rr_ptr to 2, then requesters 1 and 3 compete with special operands.
        req_valid       = 4'b0010;
        req_data[63:32] = 32'hBF80_0000;
        #1;
        chk("t6_prime_ready", 32'(req_ready), 2);
        chk("t6_prime_x", unit_x, 32'hBF80_0000);
        tick();
        req_valid        = 4'b1010;
        req_data[63:32]  = 32'h0000_0000;
        req_data[127:96] = 32'h7F80_0000;
        #1;
        chk("t6_rr_ptr2", 32'(dut.rr_ptr), 2);
        chk("t6_grant3", 32'(req_ready), 8);
        chk("t6_x_inf", unit_x, 32'h7F80_0000);
        tick();
        chk("t6_grant1", 32'(req_ready), 2);
        chk("t6_x_zero", unit_x, 0);
        tick();
        req_valid = '0;
        #1;
        chk("t6_r0_id",   32'(rsp_id), 1);
        chk("t6_r0_data", rsp_data, 32'hBF80_0000);
        tick();
        chk("t6_r1_id",   32'(rsp_id), 3);
        chk("t6_r1_data", rsp_data, 32'h7F80_0000);
        tick();
        chk("t6_r2_valid", 32'(rsp_valid), 1);
        chk("t6_r2_id",    32'(rsp_id), 1);
        chk("t6_r2_data",  rsp_data, 0);
        tick();
        chk("t6_drained", 32'(rsp_valid), 0);
        chk("t6_idle",    32'(busy), 0);

        // Reset to bring rr_ptr back to 0.
        rst = 1'b1;
        tick();
        chk("rst2_rr_ptr", 32'(dut.rr_ptr), 0);
        rst = 1'b0;
        tick();

        // All requesters streaming, consumer always ready.
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_data[i*DW +: DW] = 32'h4000_0000 + 32'(i);
        end
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk("t2_grant", 32'(req_ready), (k < 8) ? 32'(1 << (k % 4)) : 0);
            if (k < 8) chk("t2_unit_x", unit_x, 32'h4000_0000 + 32'(k % 4));
            if (k >= 3 && k < 11) begin
                chk("t2_rsp_valid", 32'(rsp_valid), 1);
                chk("t2_rsp_id",    32'(rsp_id), 32'((k - 3) % 4));
                chk("t2_rsp_data",  rsp_data, 32'h4000_0000 + 32'((k - 3) % 4));
            end else begin
                chk("t2_rsp_idle", 32'(rsp_valid), 0);
            end
            tick();
        end

        // Requester 2 streaming with consumer stalled: four accepts then stall.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            req_data[95:64] = 32'h5000_0000 + 32'((k < 4) ? k : 4);
            #1;
            chk("t3_credit", 32'(req_ready), (k < 4) ? 4 : 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_full_count", 32'(dut.fifo_count), 4);
        chk("t3_pop_no_credit", 32'(req_ready), 0);
        chk("t3_head_id",   32'(rsp_id), 2);
        chk("t3_head_data", rsp_data, 32'h5000_0000);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("t3_new_accept", 32'(req_ready), 4);
        chk("t3_count3", 32'(dut.fifo_count), 3);
        chk("t3_head1", rsp_data, 32'h5000_0001);
        tick();
        req_data[95:64] = 32'h5000_0005;
        #1;
        chk("t3_stall_a", 32'(req_ready), 0);
        tick();
        rsp_ready = 1'b1;
        #1;
        chk("t4_stall_b", 32'(req_ready), 0);
        chk("t4_head1", rsp_data, 32'h5000_0001);
        tick();
        req_valid = '0;
        #1;
        chk("t4_push_pop_count", 32'(dut.fifo_count), 3);
        chk("t4_head2", rsp_data, 32'h5000_0002);
        tick();
        chk("t4_head3", rsp_data, 32'h5000_0003);
        tick();
        chk("t4_head_wrap", rsp_data, 32'h5000_0004);
        chk("t4_head_wrap_id", 32'(rsp_id), 2);
        tick();
        chk("t4_empty", 32'(rsp_valid), 0);
        chk("t4_idle",  32'(busy), 0);

        // Fill with two buffered and two in flight, then reset mid-operation.
        rsp_ready      = 1'b0;
        req_valid      = 4'b0001;
        req_data[31:0] = 32'h6000_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_fill", 32'(req_ready), 1);
            tick();
        end
        chk("t5_full_stall", 32'(req_ready), 0);
        chk("t5_buffered", 32'(rsp_valid), 1);
        chk("t5_count2", 32'(dut.fifo_count), 2);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("t5_rsp_cleared", 32'(rsp_valid), 0);
        chk("t5_busy_cleared", 32'(busy), 0);
        chk("t5_rr_ptr", 32'(dut.rr_ptr), 0);
        chk("t5_data_cleared", rsp_data, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_stale", 32'(rsp_valid), 0);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
